// File: rtl/riscv_lsu.sv
// Load/store initiator for riscv_dmem: turns one byte-addressed RV32I load/store
// into one or two word-addressed, byte-selected dmem accesses and aligns/extends loads.
module riscv_lsu #(
  parameter int XLEN          = 32,
  parameter int DMEM_ADDR_BIT = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_req,
  output logic                     o_ready,
  input  logic                     i_we,
  input  logic [2:0]               i_funct3,
  input  logic [DMEM_ADDR_BIT-1:0] i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  output logic [XLEN-1:0]          o_rdata,
  output logic                     o_done,
  output logic                     o_err,
  output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
  output logic [XLEN/8-1:0]        o_dmem_byte_sel,
  output logic                     o_dmem_wr_en,
  output logic [XLEN-1:0]          o_dmem_data,
  input  logic [XLEN-1:0]          i_dmem_data
);

  localparam int WAW = DMEM_ADDR_BIT - 2;
  localparam int NL  = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_A0   = 2'd1;
  localparam logic [1:0] S_A1   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            we_q, err_q, split_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [WAW-1:0]  waddr_q;
  logic [NL-1:0]   hi_sel_q;
  logic [XLEN-1:0] hi_data_q, lo_q;

  logic [WAW-1:0]  daddr_q, daddr_d;
  logic [NL-1:0]   sel_q, sel_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            accept, legal_in;
  logic [NL-1:0]   lanes_in;
  logic [XLEN-1:0] dmask_in;
  logic [2*NL-1:0] sel8_in;
  logic [2*XLEN-1:0] win_in, lwin, lsh;
  logic [XLEN-1:0] ext;

  assign accept = i_req && (state_q == S_IDLE);

  always_comb begin
    case (i_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_in = 1'b1;
      default:                                legal_in = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b00:   begin lanes_in = 4'b0001; dmask_in = 32'h0000_00FF; end
      2'b01:   begin lanes_in = 4'b0011; dmask_in = 32'h0000_FFFF; end
      default: begin lanes_in = 4'b1111; dmask_in = 32'hFFFF_FFFF; end
    endcase
    // Both halves of the 8-byte window are formed at accept; the A1 half is parked until needed.
    sel8_in = {4'b0000, lanes_in} << i_addr[1:0];
    win_in  = i_we ? ({32'h0, i_wdata & dmask_in} << {i_addr[1:0], 3'b000}) : '0;
  end

  always_comb begin
    state_d = state_q;
    daddr_d = daddr_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (i_req) begin
        if (legal_in) begin
          state_d = S_A0;
          daddr_d = i_addr[DMEM_ADDR_BIT-1:2];
          sel_d   = sel8_in[3:0];
          wr_d    = i_we;
          data_d  = win_in[31:0];
        end else begin
          state_d = S_FIN;
          sel_d   = '0;
          wr_d    = 1'b0;
        end
      end
      S_A0: if (split_q) begin
        state_d = S_A1;
        daddr_d = waddr_q + {{(WAW-1){1'b0}}, 1'b1};
        sel_d   = hi_sel_q;
        wr_d    = we_q;
        data_d  = hi_data_q;
      end else begin
        state_d = S_FIN;
        sel_d   = '0;
        wr_d    = 1'b0;
      end
      S_A1: begin
        state_d = S_FIN;
        sel_d   = '0;
        wr_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      waddr_q   <= '0;
      hi_sel_q  <= '0;
      hi_data_q <= '0;
      lo_q      <= '0;
      daddr_q   <= '0;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      daddr_q <= daddr_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      if (accept) begin
        we_q      <= i_we;
        err_q     <= !legal_in;
        split_q   <= |sel8_in[7:4];
        f3_q      <= i_funct3;
        off_q     <= i_addr[1:0];
        waddr_q   <= i_addr[DMEM_ADDR_BIT-1:2];
        hi_sel_q  <= sel8_in[7:4];
        hi_data_q <= win_in[63:32];
      end
      if (state_q == S_A1) lo_q <= i_dmem_data;
    end
  end

  always_comb begin
    lwin = split_q ? {i_dmem_data, lo_q} : {32'h0, i_dmem_data};
    lsh  = lwin >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{lsh[7]}}, lsh[7:0]};
      3'b100:  ext = {24'h0, lsh[7:0]};
      3'b001:  ext = {{16{lsh[15]}}, lsh[15:0]};
      3'b101:  ext = {16'h0, lsh[15:0]};
      default: ext = lsh[31:0];
    endcase
  end

  assign o_ready         = (state_q == S_IDLE);
  assign o_done          = (state_q == S_FIN);
  assign o_err           = (state_q == S_FIN) && err_q;
  assign o_rdata         = ((state_q == S_FIN) && !we_q && !err_q) ? ext : '0;
  assign o_dmem_addr     = daddr_q;
  assign o_dmem_byte_sel = sel_q;
  assign o_dmem_wr_en    = wr_q;
  assign o_dmem_data     = data_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a word-wide dmem stand-in plus a byte-array reference memory
// that predicts every load, latency and error outcome.
module tb_riscv_lsu;
  localparam int AW = 12;
  localparam int NB = 4096;
  localparam int NW = 1024;

  logic        clk, i_rstn, i_req, i_we;
  logic [2:0]  i_funct3;
  logic [11:0] i_addr;
  logic [31:0] i_wdata, o_rdata, o_dmem_data, i_dmem_data;
  logic        o_ready, o_done, o_err, o_dmem_wr_en;
  logic [9:0]  o_dmem_addr;
  logic [3:0]  o_dmem_byte_sel;

  riscv_lsu #(.XLEN(32), .DMEM_ADDR_BIT(AW)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_req(i_req), .o_ready(o_ready), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_done(o_done), .o_err(o_err), .o_dmem_addr(o_dmem_addr),
    .o_dmem_byte_sel(o_dmem_byte_sel), .o_dmem_wr_en(o_dmem_wr_en),
    .o_dmem_data(o_dmem_data), .i_dmem_data(i_dmem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // dmem stand-in: synchronous write of selected lanes, read data one cycle after address
  logic [31:0] dmem [NW];
  logic        mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int w = 0; w < NW; w++) dmem[w] <= pat(w);
    end else if (o_dmem_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (o_dmem_byte_sel[k]) dmem[o_dmem_addr][8*k +: 8] <= o_dmem_data[8*k +: 8];
    end
    i_dmem_data <= dmem[o_dmem_addr];
  end

  logic [7:0] ref_mem [NB];
  int errors, checks;

  int          cyc, wr_cnt, wait_n;
  logic        got_err;
  logic [31:0] got_rdata;
  logic [9:0]  a0_addr, a1_addr;
  logic [3:0]  a0_sel, a1_sel;
  logic [31:0] a0_data, a1_data;
  logic        a0_wr, a1_wr;

  function automatic int unsigned fsize(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit flegal(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [11:0] a);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < fsize(f3); i++) v[8*i +: 8] = ref_mem[(32'(a) + i) % NB];
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
    for (int unsigned i = 0; i < fsize(f3); i++) ref_mem[(32'(a) + i) % NB] = wd[8*i +: 8];
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] wd, input bit hold);
    bit done;
    wait_n = 0;
    @(negedge clk);
    while (!o_ready && wait_n < 10) begin @(negedge clk); wait_n++; end
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(posedge clk); #1;
    if (!hold) i_req = 1'b0;
    cyc = 0; wr_cnt = 0; done = 1'b0; got_err = 1'b0; got_rdata = '0;
    {a0_addr, a0_sel, a0_data, a0_wr, a1_addr, a1_sel, a1_data, a1_wr} = '0;
    while (cyc < 8 && !done) begin
      @(negedge clk);
      cyc++;
      if (o_dmem_wr_en) wr_cnt++;
      if (cyc == 1) {a0_addr, a0_sel, a0_data, a0_wr} = {o_dmem_addr, o_dmem_byte_sel, o_dmem_data, o_dmem_wr_en};
      if (cyc == 2) {a1_addr, a1_sel, a1_data, a1_wr} = {o_dmem_addr, o_dmem_byte_sel, o_dmem_data, o_dmem_wr_en};
      if (o_done) begin done = 1'b1; got_rdata = o_rdata; got_err = o_err; end
    end
    i_req = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL timeout: o_done not seen within %0d cycles (addr=%h)", cyc, a); end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_dmem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", o_dmem_wr_en); end
    checks++; if (o_dmem_byte_sel !== 4'b0) begin errors++; $display("FAIL reset_sel: got %b want 0000", o_dmem_byte_sel); end
    checks++; if ({o_done, o_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {o_done, o_err}); end
    checks++; if ({o_rdata, o_dmem_data, o_dmem_addr} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%h want 0", o_rdata, o_dmem_data, o_dmem_addr); end
    @(negedge clk); i_rstn = 1'b1;
  endtask

  task automatic test_word;
    access(1'b1, 3'b010, 12'h008, 32'hDEADBEEF, 1'b0); ref_store(3'b010, 12'h008, 32'hDEADBEEF);
    checks++; if ({a0_addr, a0_sel, a0_wr} !== {10'd2, 4'b1111, 1'b1}) begin errors++; $display("FAIL sw_a0_ctl: got %h/%b/%b want 2/1111/1", a0_addr, a0_sel, a0_wr); end
    checks++; if (a0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_a0_data: got %h want deadbeef", a0_data); end
    access(1'b0, 3'b010, 12'h008, 32'h0, 1'b0);
    checks++; if (cyc != 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", cyc); end
    checks++; if (got_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", got_rdata); end
  endtask

  task automatic test_byte;
    access(1'b1, 3'b000, 12'h005, 32'h0000_0080, 1'b0); ref_store(3'b000, 12'h005, 32'h80);
    checks++; if ({a0_sel, a0_data} !== {4'b0010, 32'h0000_8000}) begin errors++; $display("FAIL sb_lane: got %b/%h want 0010/00008000", a0_sel, a0_data); end
    access(1'b0, 3'b000, 12'h005, 32'h0, 1'b0);
    checks++; if (got_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sign: got %h want ffffff80", got_rdata); end
    access(1'b0, 3'b100, 12'h005, 32'h0, 1'b0);
    checks++; if (got_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zero: got %h want 00000080", got_rdata); end
  endtask

  task automatic test_split;
    access(1'b1, 3'b010, 12'h006, 32'h44332211, 1'b0); ref_store(3'b010, 12'h006, 32'h44332211);
    checks++; if ({a0_addr, a0_sel, a0_data} !== {10'd1, 4'b1100, 32'h2211_0000}) begin errors++; $display("FAIL split_a0: got %h/%b/%h want 1/1100/22110000", a0_addr, a0_sel, a0_data); end
    checks++; if ({a1_addr, a1_sel, a1_data, a1_wr} !== {10'd2, 4'b0011, 32'h0000_4433, 1'b1}) begin errors++; $display("FAIL split_a1: got %h/%b/%h/%b want 2/0011/00004433/1", a1_addr, a1_sel, a1_data, a1_wr); end
    access(1'b0, 3'b010, 12'h006, 32'h0, 1'b0);
    checks++; if (cyc != 3) begin errors++; $display("FAIL split_latency: got %0d want 3", cyc); end
    checks++; if (got_rdata !== 32'h44332211) begin errors++; $display("FAIL split_lw: got %h want 44332211", got_rdata); end
  endtask

  task automatic test_wrap;
    access(1'b1, 3'b000, 12'hFFF, 32'h34, 1'b0); ref_store(3'b000, 12'hFFF, 32'h34);
    access(1'b1, 3'b000, 12'h000, 32'h9A, 1'b0); ref_store(3'b000, 12'h000, 32'h9A);
    access(1'b0, 3'b001, 12'hFFF, 32'h0, 1'b0);
    checks++; if ({a0_addr, a1_addr, a1_sel} !== {10'h3FF, 10'h000, 4'b0001}) begin errors++; $display("FAIL wrap_addr: got %h/%h/%b want 3ff/000/0001", a0_addr, a1_addr, a1_sel); end
    checks++; if (got_rdata !== 32'hFFFF_9A34) begin errors++; $display("FAIL wrap_lh: got %h want ffff9a34", got_rdata); end
    access(1'b0, 3'b101, 12'hFFF, 32'h0, 1'b0);
    checks++; if (got_rdata !== 32'h0000_9A34) begin errors++; $display("FAIL wrap_lhu: got %h want 00009a34", got_rdata); end
  endtask

  task automatic test_illegal;
    logic [2:0] bad [3];
    bad = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      access(1'b1, bad[i], 12'h010, 32'hCAFEF00D, 1'b0);
      checks++; if ({cyc, got_err, got_rdata, wr_cnt} !== {32'd1, 1'b1, 32'h0, 32'd0}) begin errors++; $display("FAIL illegal_f3_%0d: got cyc=%0d err=%b rdata=%h wr=%0d want 1/1/0/0", bad[i], cyc, got_err, got_rdata, wr_cnt); end
    end
    access(1'b0, 3'b010, 12'h010, 32'h0, 1'b0);
    checks++; if (got_rdata !== ref_load(3'b010, 12'h010)) begin errors++; $display("FAIL illegal_untouched: got %h want %h", got_rdata, ref_load(3'b010, 12'h010)); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 12'h022; i_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk);
    checks++; if ({o_dmem_wr_en, o_dmem_byte_sel} !== {1'b1, 4'b1100}) begin errors++; $display("FAIL rstmid_a0: got %b/%b want 1/1100", o_dmem_wr_en, o_dmem_byte_sel); end
    @(posedge clk); #2;
    i_rstn = 1'b0; #1;
    checks++; if ({o_dmem_wr_en, o_dmem_byte_sel, o_ready} !== {1'b0, 4'b0000, 1'b1}) begin errors++; $display("FAIL rstmid_async: got wr=%b sel=%b rdy=%b want 0/0000/1", o_dmem_wr_en, o_dmem_byte_sel, o_ready); end
    @(negedge clk); i_rstn = 1'b1;
    ref_mem[12'h022] = 8'hD4; ref_mem[12'h023] = 8'hC3;
    access(1'b0, 3'b010, 12'h020, 32'h0, 1'b0);
    checks++; if (got_rdata !== ref_load(3'b010, 12'h020)) begin errors++; $display("FAIL rstmid_lo: got %h want %h", got_rdata, ref_load(3'b010, 12'h020)); end
    access(1'b0, 3'b010, 12'h024, 32'h0, 1'b0);
    checks++; if (got_rdata !== ref_load(3'b010, 12'h024)) begin errors++; $display("FAIL rstmid_hi: got %h want %h", got_rdata, ref_load(3'b010, 12'h024)); end
  endtask

  task automatic test_back_to_back;
    access(1'b0, 3'b010, 12'h100, 32'h0, 1'b1);
    checks++; if ({cyc, wr_cnt} !== {32'd2, 32'd0}) begin errors++; $display("FAIL held_req: got cyc=%0d wr=%0d want 2/0", cyc, wr_cnt); end
    access(1'b1, 3'b001, 12'h103, 32'h0000_BEEF, 1'b0); ref_store(3'b001, 12'h103, 32'hBEEF);
    checks++; if ({wait_n, cyc} !== {32'd0, 32'd3}) begin errors++; $display("FAIL b2b_store: got wait=%0d cyc=%0d want 0/3", wait_n, cyc); end
    access(1'b0, 3'b001, 12'h103, 32'h0, 1'b0);
    checks++; if ({wait_n, got_rdata} !== {32'd0, 32'hFFFF_BEEF}) begin errors++; $display("FAIL b2b_load: got wait=%0d rdata=%h want 0/ffffbeef", wait_n, got_rdata); end
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] wd, exp_rd;
    int          exp_cyc, exp_wr;
    for (int n = 0; n < 120; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4088, 4095)) : 12'($urandom_range(0, 4095));
      wd = $urandom;
      exp_rd  = (!we && flegal(f3)) ? ref_load(f3, a) : 32'h0;
      exp_cyc = !flegal(f3) ? 1 : ((32'(a[1:0]) + fsize(f3) > 4) ? 3 : 2);
      exp_wr  = (we && flegal(f3)) ? exp_cyc - 1 : 0;
      access(we, f3, a, wd, 1'b0);
      if (we && flegal(f3)) ref_store(f3, a, wd);
      checks++;
      if (cyc != exp_cyc || got_err !== !flegal(f3) || got_rdata !== exp_rd || wr_cnt != exp_wr) begin
        errors++;
        $display("FAIL rand_%0d we=%b f3=%b a=%h: got cyc=%0d err=%b rd=%h wr=%0d want %0d/%b/%h/%0d",
                 n, we, f3, a, cyc, got_err, got_rdata, wr_cnt, exp_cyc, !flegal(f3), exp_rd, exp_wr);
      end
    end
  endtask

  task automatic test_mem_image;
    logic [31:0] exp_w;
    repeat (2) @(negedge clk);
    for (int w = 0; w < NW; w++) begin
      exp_w = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      checks++;
      if (dmem[w] !== exp_w) begin errors++; $display("FAIL mem_word_%0d: got %h want %h", w, dmem[w], exp_w); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    i_rstn = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    mem_ready = 1'b0;
    for (int w = 0; w < NW; w++) begin
      logic [31:0] p;
      p = pat(w);
      for (int k = 0; k < 4; k++) ref_mem[4*w+k] = p[8*k +: 8];
    end
    repeat (3) @(posedge clk);
    mem_ready = 1'b1;
    test_reset;
    test_word;
    test_byte;
    test_split;
    test_wrap;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_mem_image;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
